// File: rtl/raccoon_lut_pkg.sv
// Shared definitions for the constant-multiple lookup table and its decoder.
//   LUT_W   : width of table entries / dividend / remainder
//   LUT_KW  : table index (quotient) width, table depth 2**LUT_KW
//   LUT_C   : table step, also the constant divisor of the decoder
//   lut_state_e : decoder FSM states
package raccoon_lut_pkg;

  localparam int unsigned LUT_W  = 49;
  localparam int unsigned LUT_KW = 5;
  localparam logic [LUT_W-1:0] LUT_C = 49'd13125370249215;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } lut_state_e;

endpackage

// File: rtl/lut5_div_step.sv
// One restoring-division step against a constant divisor.
//   rem_i   : partial remainder, W+1 bits so C<<shift never truncates
//   shift_i : bit position of the quotient bit being resolved
//   rem_o   : rem_i - (C<<shift_i) if that is non-negative, else rem_i
//   qbit_o  : 1 when the subtraction was taken
module lut5_div_step
  import raccoon_lut_pkg::*;
#(
  parameter int unsigned      W  = LUT_W,
  parameter int unsigned      IW = 3,
  parameter logic [W-1:0]     C  = LUT_C
) (
  input  logic [W:0]    rem_i,
  input  logic [IW-1:0] shift_i,
  output logic [W:0]    rem_o,
  output logic          qbit_o
);

  logic [W:0] divisor;

  always_comb begin
    divisor = {1'b0, C} << shift_i;
    qbit_o  = (rem_i >= divisor);
    rem_o   = qbit_o ? (rem_i - divisor) : rem_i;
  end

endmodule

// File: rtl/lut5_quotient_decoder.sv
// Inverse of the constant-multiple table: recovers k = floor(x/C) and
// r = x - k*C with a sequential radix-2 restoring divider (one bit per cycle).
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : dividend handshake (in_ready only in IDLE)
//   x                   : dividend, sampled at the input handshake
//   out_valid/out_ready : result handshake; results held until accepted
//   q                   : quotient, saturates at 2**KW-1
//   r                   : remainder, always x - q*C
//   ovf                 : x >= 2**KW * C
module lut5_quotient_decoder
  import raccoon_lut_pkg::*;
#(
  parameter int unsigned  W  = LUT_W,
  parameter int unsigned  KW = LUT_KW,
  parameter logic [W-1:0] C  = LUT_C
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [KW-1:0] q,
  output logic [W-1:0]  r,
  output logic          ovf
);

  localparam int unsigned IW = (KW > 1) ? $clog2(KW) : 1;
  localparam logic [W:0]  OVF_LIM = {1'b0, C} << KW;

  lut_state_e    state_q;
  logic [W:0]    rem_q;
  logic [KW-1:0] quo_q;
  logic [IW-1:0] cnt_q;
  logic          ovf_q;
  logic          in_ready_q;
  logic          out_valid_q;

  logic [W:0]    rem_d;
  logic          qbit_d;

  lut5_div_step #(
    .W  (W),
    .IW (IW),
    .C  (C)
  ) u_step (
    .rem_i   (rem_q),
    .shift_i (cnt_q),
    .rem_o   (rem_d),
    .qbit_o  (qbit_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            rem_q      <= {1'b0, x};
            ovf_q      <= ({1'b0, x} >= OVF_LIM);
            quo_q      <= '0;
            cnt_q      <= IW'(KW - 1);
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          // Quotient bits resolve MSB first, so shifting in from the LSB
          // places each bit at its final position after KW steps. Overflowing
          // inputs simply leave every bit set, which yields the saturated q.
          rem_q <= rem_d;
          quo_q <= {quo_q[KW-2:0], qbit_d};
          if (cnt_q == '0) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign q         = quo_q;
  // Remainder never exceeds x, so its top working bit is always zero here.
  assign r         = rem_q[W-1:0];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_lut5_quotient_decoder.sv
module tb_lut5_quotient_decoder;

  localparam longint unsigned CL   = 64'd13125370249215;
  localparam longint unsigned XMAX = (64'd1 << 49) - 1;

  typedef struct {
    longint unsigned x;
    longint unsigned q;
    longint unsigned r;
    longint unsigned ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [48:0] x = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  q;
  logic [48:0] r;
  logic        ovf;

  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   results = 0;
  bit   rnd_rdy = 1'b0;
  exp_t sb_q[$];

  lut5_quotient_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division with saturation.
  function automatic exp_t model(input longint unsigned xv);
    exp_t e;
    longint unsigned k;
    k     = xv / CL;
    e.x   = xv;
    e.q   = (k > 31) ? 64'd31 : k;
    e.r   = xv - e.q * CL;
    e.ovf = (k >= 32) ? 64'd1 : 64'd0;
    return e;
  endfunction

  task automatic chk(input string name, input longint unsigned got,
                     input longint unsigned expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", name, got, expv, $time);
    end
  endtask

  task automatic send(input longint unsigned xv, input bit expect_it);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout waited=%0d cycles", n);
      return;
    end
    in_valid = 1'b1;
    x        = xv[48:0];
    if (expect_it) begin
      sb_q.push_back(model(xv));
      pushed++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit seen);
    int unsigned n;
    n = 0;
    seen = 1'b0;
    while (n < 50) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        return;
      end
      n++;
    end
    checks++;
    errors++;
    $display("FAIL out_valid_timeout waited=%0d cycles", n);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb_q.size(), 0);
  endtask

  // Monitor: every accepted result is popped and compared.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result got q=%0d r=%0d required none", q, r);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        results++;
        chk("q", q, e.q);
        chk("r", r, e.r);
        chk("ovf", ovf, e.ovf);
        chk("identity_qC_plus_r", longint'(q) * CL + longint'(r), e.x);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    int unsigned lat;
    logic [4:0]  sq;
    logic [48:0] sr;
    logic        so;
    bit          stray;

    // Reset values
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_ovf", ovf, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_release", in_ready, 1);

    // x=0 with latency and in_ready return
    out_ready = 1'b1;
    send(0, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency_cycles", lat, 5);
    chk("in_ready_in_done", in_ready, 0);
    @(posedge clk);
    #1;
    chk("in_ready_after_out_hs", in_ready, 1);
    chk("out_valid_dropped", out_valid, 0);

    // Directed boundaries
    send(64'd170629813239800, 1);
    send(64'd406886477725665, 1);
    send(64'd406886477725664, 1);
    send(64'd420011847974880, 1);
    send(64'd562949953421311, 1);
    drain();

    // Backpressure: held result, stray in_valid pulses not consumed
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(64'd5 * CL + 64'd77, 1);
    wait_valid(seen);
    if (seen) begin
      sq = q;
      sr = r;
      so = ovf;
      for (int i = 0; i < 10; i++) begin
        in_valid = 1'($urandom_range(0, 1));
        x        = {$urandom, $urandom};
        @(negedge clk);
        chk("bp_q_stable", q, sq);
        chk("bp_r_stable", r, sr);
        chk("bp_ovf_stable", ovf, so);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_released", out_valid, 0);
    end
    drain();

    // Reset in the third CALC cycle aborts the operation
    send(64'd9 * CL + 64'd3, 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    void'(sb_q.pop_back());
    pushed--;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) stray = 1'b1;
    end
    chk("abort_no_result", stray, 0);
    send(64'd26250740498430, 1);
    drain();

    // Random sweep, partly clustered near multiples of C
    rnd_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      longint unsigned xv;
      if (i % 2 == 0) begin
        xv = {$urandom, $urandom} & XMAX;
      end else begin
        xv = longint'($urandom_range(0, 42)) * CL + longint'($urandom_range(0, 4))
             - longint'($urandom_range(0, 2));
        if (xv > XMAX) xv = XMAX;
      end
      send(xv, 1);
    end
    rnd_rdy = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    chk("result_count", results, pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
